// File: rtl/picorv32_rvfimon.sv
// Passive RVFI retirement monitor for picorv32_axi: checks order, PC chain, x0, shadow
// register reads and memory masks, and latches the first failure as a sticky error code.
module picorv32_rvfimon #(
  parameter bit CHECK_REGS = 1'b1,
  parameter bit CHECK_MEM  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_halt,
  input  logic        rvfi_intr,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rs1_rdata,
  input  logic [31:0] rvfi_rs2_rdata,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  input  logic [31:0] rvfi_mem_rdata,
  input  logic [31:0] rvfi_mem_wdata,
  output logic        error,
  output logic [2:0]  error_code,
  output logic [63:0] insn_count
);

  logic [63:0] expected_order;
  logic [31:0] prev_pc_wdata;
  logic        have_prev_pc;
  logic        halted;
  logic [31:0] shadow [32];
  logic [31:0] shadow_valid;
  logic [7:1]  fail;
  logic [2:0]  first_code;
  logic        rmask_nz;
  logic        wmask_nz;

  // Trap status, the instruction word and memory data are trace-only here.
  logic unused_inputs;
  assign unused_inputs = ^{rvfi_insn, rvfi_trap, rvfi_mem_rdata, rvfi_mem_wdata,
                           rvfi_mem_addr[31:2]};

  function automatic logic mask_legal(input logic [3:0] m);
    case (m)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_legal = 1'b1;
      default:                   mask_legal = 1'b0;
    endcase
  endfunction

  assign rmask_nz = rvfi_mem_rmask != 4'd0;
  assign wmask_nz = rvfi_mem_wmask != 4'd0;

  // The shadow is read combinationally, so rd==rs1 compares against the pre-write value.
  always_comb begin
    fail    = '0;
    fail[1] = rvfi_order != expected_order;
    fail[2] = have_prev_pc && !rvfi_intr && (rvfi_pc_rdata != prev_pc_wdata);
    fail[3] = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
    fail[4] = ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != 32'd0)) ||
              (CHECK_REGS && shadow_valid[rvfi_rs1_addr] &&
               (rvfi_rs1_rdata != shadow[rvfi_rs1_addr]));
    fail[5] = ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != 32'd0)) ||
              (CHECK_REGS && shadow_valid[rvfi_rs2_addr] &&
               (rvfi_rs2_rdata != shadow[rvfi_rs2_addr]));
    fail[6] = CHECK_MEM && (!mask_legal(rvfi_mem_rmask) || !mask_legal(rvfi_mem_wmask) ||
                            (rmask_nz && wmask_nz) ||
                            ((rmask_nz || wmask_nz) && (rvfi_mem_addr[1:0] != 2'b00)));
    fail[7] = halted;
  end

  always_comb begin
    first_code = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (fail[i]) first_code = 3'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error          <= 1'b0;
      error_code     <= 3'd0;
      insn_count     <= 64'd0;
      expected_order <= 64'd0;
      prev_pc_wdata  <= 32'd0;
      have_prev_pc   <= 1'b0;
      halted         <= 1'b0;
      shadow_valid   <= 32'd0;
    end else if (rvfi_valid) begin
      expected_order <= expected_order + 64'd1;
      insn_count     <= insn_count + 64'd1;
      prev_pc_wdata  <= rvfi_pc_wdata;
      have_prev_pc   <= 1'b1;
      if (rvfi_halt) halted <= 1'b1;
      if (!error && (first_code != 3'd0)) begin
        error      <= 1'b1;
        error_code <= first_code;
      end
      if (rvfi_rd_addr != 5'd0) shadow_valid[rvfi_rd_addr] <= 1'b1;
    end
  end

  // Data is only meaningful where shadow_valid is set, so it needs no reset.
  always_ff @(posedge clock) begin
    if (rvfi_valid && (rvfi_rd_addr != 5'd0)) shadow[rvfi_rd_addr] <= rvfi_rd_wdata;
  end

endmodule

// File: tb/tb_picorv32_rvfimon.sv
// Directed self-checking bench for picorv32_rvfimon: one task per check scenario.
module tb_picorv32_rvfimon;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap, rvfi_halt, rvfi_intr;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
  logic [31:0] rvfi_mem_rdata, rvfi_mem_wdata;
  logic        error;
  logic [2:0]  error_code;
  logic [63:0] insn_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  picorv32_rvfimon dut (
    .clock(clock), .reset(reset),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata),
    .error(error), .error_code(error_code), .insn_count(insn_count)
  );

  task automatic clear_fields();
    rvfi_valid = 0; rvfi_order = 0; rvfi_insn = 32'h13;
    rvfi_trap = 0; rvfi_halt = 0; rvfi_intr = 0;
    rvfi_rs1_addr = 0; rvfi_rs2_addr = 0; rvfi_rd_addr = 0;
    rvfi_rs1_rdata = 0; rvfi_rs2_rdata = 0; rvfi_rd_wdata = 0;
    rvfi_pc_rdata = 0; rvfi_pc_wdata = 0;
    rvfi_mem_addr = 0; rvfi_mem_rmask = 0; rvfi_mem_wmask = 0;
    rvfi_mem_rdata = 0; rvfi_mem_wdata = 0;
  endtask

  task automatic set_pc(input logic [63:0] order, input logic [31:0] pcr, input logic [31:0] pcw);
    rvfi_order = order; rvfi_pc_rdata = pcr; rvfi_pc_wdata = pcw;
  endtask

  // Presents the staged fields for exactly one cycle; outputs are sampled 1 time unit later.
  task automatic retire();
    rvfi_valid = 1;
    @(posedge clock); #1;
    clear_fields();
  endtask

  task automatic do_reset();
    clear_fields();
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    clear_fields();
    reset = 1;
    @(posedge clock); #1;
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %0b expected 0", error); end
    checks++; if (error_code !== 3'd0) begin errors++; $display("[TB] FAIL reset_code: got %0d expected 0", error_code); end
    checks++; if (insn_count !== 64'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", insn_count); end
    reset = 0;
  endtask

  task automatic test_basic_chain();
    do_reset();
    set_pc(0, 32'h0, 32'h4); rvfi_rd_addr = 5; rvfi_rd_wdata = 7; retire();
    checks++; if (insn_count !== 64'd1) begin errors++; $display("[TB] FAIL chain_count1: got %0d expected 1", insn_count); end
    set_pc(1, 32'h4, 32'h8); rvfi_rs1_addr = 5; rvfi_rs1_rdata = 7; retire();
    set_pc(2, 32'h8, 32'hc); rvfi_rs2_addr = 5; rvfi_rs2_rdata = 7; rvfi_trap = 1; retire();
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL chain_error: got %0b expected 0", error); end
    checks++; if (insn_count !== 64'd3) begin errors++; $display("[TB] FAIL chain_count3: got %0d expected 3", insn_count); end
    // idle cycles with junk on the trace must not count or check
    rvfi_order = 64'h55; rvfi_rd_wdata = 32'h1; rvfi_pc_rdata = 32'h999;
    repeat (3) @(posedge clock); #1;
    clear_fields();
    checks++; if (insn_count !== 64'd3 || error !== 1'b0) begin errors++; $display("[TB] FAIL idle_hold: got count %0d err %0b expected 3/0", insn_count, error); end
  endtask

  task automatic test_order();
    do_reset();
    set_pc(0, 32'h0, 32'h4); retire();
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL order_first: got %0b expected 0", error); end
    set_pc(2, 32'h4, 32'h8); retire();
    checks++; if (error !== 1'b1 || error_code !== 3'd1) begin errors++; $display("[TB] FAIL order_skip: got err %0b code %0d expected 1/1", error, error_code); end
    // expected order is now 2; a PC break here must not overwrite code 1
    set_pc(2, 32'h100, 32'h104); retire();
    checks++; if (error !== 1'b1 || error_code !== 3'd1) begin errors++; $display("[TB] FAIL order_sticky: got err %0b code %0d expected 1/1", error, error_code); end
  endtask

  task automatic test_pc();
    do_reset();
    set_pc(0, 32'h0, 32'h10); retire();
    set_pc(1, 32'h20, 32'h24); retire();
    checks++; if (error_code !== 3'd2) begin errors++; $display("[TB] FAIL pc_break: got %0d expected 2", error_code); end
    do_reset();
    set_pc(0, 32'h0, 32'h10); retire();
    set_pc(1, 32'h20, 32'h24); rvfi_intr = 1; retire();
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL pc_intr: got %0b expected 0", error); end
  endtask

  task automatic test_regs();
    do_reset();
    set_pc(0, 32'h0, 32'h4); rvfi_rd_addr = 0; rvfi_rd_wdata = 5; retire();
    checks++; if (error_code !== 3'd3) begin errors++; $display("[TB] FAIL x0_write: got %0d expected 3", error_code); end
    do_reset();
    set_pc(0, 32'h0, 32'h4); rvfi_rd_addr = 3; rvfi_rd_wdata = 9; retire();
    set_pc(1, 32'h4, 32'h8); rvfi_rs1_addr = 3; rvfi_rs1_rdata = 8; retire();
    checks++; if (error_code !== 3'd4) begin errors++; $display("[TB] FAIL rs1_shadow: got %0d expected 4", error_code); end
    do_reset();
    set_pc(0, 32'h0, 32'h4); rvfi_rs2_addr = 0; rvfi_rs2_rdata = 1; retire();
    checks++; if (error_code !== 3'd5) begin errors++; $display("[TB] FAIL rs2_x0: got %0d expected 5", error_code); end
    // rd == rs1 reads the old value; the new one is visible next retirement
    do_reset();
    set_pc(0, 32'h0, 32'h4); rvfi_rd_addr = 3; rvfi_rd_wdata = 9; retire();
    set_pc(1, 32'h4, 32'h8); rvfi_rs1_addr = 3; rvfi_rs1_rdata = 9; rvfi_rd_addr = 3; rvfi_rd_wdata = 1; retire();
    set_pc(2, 32'h8, 32'hc); rvfi_rs2_addr = 3; rvfi_rs2_rdata = 1; retire();
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL rd_eq_rs1: got err %0b code %0d expected 0", error, error_code); end
  endtask

  task automatic test_mem();
    do_reset();
    set_pc(0, 32'h0, 32'h4); rvfi_mem_addr = 32'h100; rvfi_mem_wmask = 4'b0110; retire();
    checks++; if (error_code !== 3'd6) begin errors++; $display("[TB] FAIL mem_badmask: got %0d expected 6", error_code); end
    do_reset();
    set_pc(0, 32'h0, 32'h4); rvfi_mem_addr = 32'h102; rvfi_mem_wmask = 4'b1111; retire();
    checks++; if (error_code !== 3'd6) begin errors++; $display("[TB] FAIL mem_misalign: got %0d expected 6", error_code); end
    do_reset();
    set_pc(0, 32'h0, 32'h4); rvfi_mem_addr = 32'h100; rvfi_mem_rmask = 4'b0011; retire();
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL mem_legal: got %0b expected 0", error); end
    do_reset();
    set_pc(0, 32'h0, 32'h4); rvfi_mem_addr = 32'h100; rvfi_mem_rmask = 4'b0001; rvfi_mem_wmask = 4'b0001; retire();
    checks++; if (error_code !== 3'd6) begin errors++; $display("[TB] FAIL mem_both: got %0d expected 6", error_code); end
  endtask

  task automatic test_halt();
    do_reset();
    set_pc(0, 32'h0, 32'h4); rvfi_halt = 1; retire();
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL halt_first: got %0b expected 0", error); end
    set_pc(1, 32'h4, 32'h8); retire();
    checks++; if (error_code !== 3'd7) begin errors++; $display("[TB] FAIL halt_after: got %0d expected 7", error_code); end
  endtask

  task automatic test_priority();
    do_reset();
    set_pc(1, 32'h0, 32'h4); rvfi_rd_addr = 0; rvfi_rd_wdata = 5; rvfi_mem_wmask = 4'b0110; retire();
    checks++; if (error_code !== 3'd1) begin errors++; $display("[TB] FAIL priority: got %0d expected 1", error_code); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_pc(0, 32'h0, 32'h4); retire();
    set_pc(5, 32'h4, 32'h8); retire();
    #2;
    reset = 1;
    #1;
    checks++; if (error !== 1'b0 || error_code !== 3'd0 || insn_count !== 64'd0) begin errors++; $display("[TB] FAIL reset_async: got err %0b code %0d count %0d expected 0/0/0", error, error_code, insn_count); end
    @(posedge clock); #1;
    reset = 0;
    set_pc(0, 32'h500, 32'h504); retire();
    checks++; if (error !== 1'b0 || insn_count !== 64'd1) begin errors++; $display("[TB] FAIL reset_restart: got err %0b count %0d expected 0/1", error, insn_count); end
  endtask

  initial begin
    clear_fields();
    test_reset();
    test_basic_chain();
    test_order();
    test_pc();
    test_regs();
    test_mem();
    test_halt();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
